// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes decoder-numbered instruction requests (op_idx 0..53) into 32-bit
//   MIPS-style instruction words, queues them in a small FIFO and emits each
//   word with its instruction-memory byte address. Unknown op_idx values
//   (54..63) are accepted and dropped, pulsing illegal for one cycle.
//
// Parameters
//   BASE_ADDR  byte address given to the first word emitted after reset
//   DEPTH      FIFO entries, power of two, 2..16
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           request handshake
//   op_idx, rs, rt, rd, shamt,
//   immediate, address            request fields
//   out_valid / out_ready         output handshake
//   out_word, out_addr            FIFO head word and its byte address
//   illegal                       one-cycle pulse after a rejected op_idx
//   count                         FIFO occupancy
//   err_cnt                       saturating illegal-request counter, present
//                                 only when INSTR_ENCODER_ERRCNT_EN is defined

module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  op_idx,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] immediate,
   input  logic [25:0] address,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [31:0] out_addr,
   output logic        illegal,
   output logic [4:0]  count
`ifdef INSTR_ENCODER_ERRCNT_EN
   ,
   output logic [7:0]  err_cnt
`endif
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] DEPTH_C = 5'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [4:0]    count_q;
   logic [31:0]   addr_q;
   logic          illegal_q;

   logic          is_special;
   logic [5:0]    funct;
   logic          is_itype;
   logic [5:0]    opc;
   logic [31:0]   enc_word;
   logic          enc_legal;

   logic          push;
   logic          pop;
   logic          push_word;

   // SPECIAL group: opcode 0, function code selects the operation
   always_comb begin
      is_special = 1'b1;
      funct      = 6'h00;
      case (op_idx)
         6'd0:  funct = 6'h20;
         6'd1:  funct = 6'h21;
         6'd2:  funct = 6'h22;
         6'd3:  funct = 6'h23;
         6'd4:  funct = 6'h24;
         6'd5:  funct = 6'h25;
         6'd6:  funct = 6'h26;
         6'd7:  funct = 6'h27;
         6'd8:  funct = 6'h2A;
         6'd9:  funct = 6'h2B;
         6'd10: funct = 6'h00;
         6'd11: funct = 6'h02;
         6'd12: funct = 6'h03;
         6'd13: funct = 6'h04;
         6'd14: funct = 6'h06;
         6'd15: funct = 6'h07;
         6'd16: funct = 6'h08;
         6'd32: funct = 6'h09;
         6'd33: funct = 6'h11;
         6'd34: funct = 6'h13;
         6'd35: funct = 6'h10;
         6'd36: funct = 6'h12;
         6'd44: funct = 6'h0D;
         6'd45: funct = 6'h0C;
         6'd46: funct = 6'h34;
         6'd49: funct = 6'h18;
         6'd50: funct = 6'h19;
         6'd51: funct = 6'h1A;
         6'd52: funct = 6'h1B;
         default: is_special = 1'b0;
      endcase
   end

   // I-type group: primary opcode selects the operation
   always_comb begin
      is_itype = 1'b1;
      opc      = 6'h00;
      case (op_idx)
         6'd17: opc = 6'h08;
         6'd18: opc = 6'h09;
         6'd19: opc = 6'h0C;
         6'd20: opc = 6'h0D;
         6'd21: opc = 6'h0E;
         6'd22: opc = 6'h23;
         6'd23: opc = 6'h2B;
         6'd24: opc = 6'h04;
         6'd25: opc = 6'h05;
         6'd26: opc = 6'h0A;
         6'd27: opc = 6'h0B;
         6'd28: opc = 6'h0F;
         6'd37: opc = 6'h28;
         6'd38: opc = 6'h29;
         6'd39: opc = 6'h20;
         6'd40: opc = 6'h21;
         6'd41: opc = 6'h24;
         6'd42: opc = 6'h25;
         6'd53: opc = 6'h01;
         default: is_itype = 1'b0;
      endcase
   end

   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b1;
      if (is_special) begin
         enc_word = {6'h00, rs, rt, rd, shamt, funct};
      end else if (is_itype) begin
         // BGEZ shares REGIMM opcode 01; the rt slot carries the sub-opcode
         enc_word = {opc, rs, (op_idx == 6'd53) ? 5'd1 : rt, immediate};
      end else begin
         case (op_idx)
            6'd29:   enc_word = {6'h02, address};
            6'd30:   enc_word = {6'h03, address};
            6'd31:   enc_word = {6'h1C, rs, rt, rd, 5'd0, 6'h20};
            6'd43:   enc_word = 32'h4200_0018;
            6'd47:   enc_word = {6'h10, 5'd0, rt, rd, 11'd0};
            6'd48:   enc_word = {6'h10, 5'd4, rt, rd, 11'd0};
            default: enc_legal = 1'b0;
         endcase
      end
   end

   // Handshakes are masked during reset so nothing completes in a reset cycle.
   // A full FIFO never grants in_ready, even if it pops in the same cycle.
   assign in_ready  = !rst && (count_q < DEPTH_C);
   assign out_valid = !rst && (count_q != 5'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign push_word = push && enc_legal;

   assign out_word  = out_valid ? mem[rd_ptr] : 32'h0;
   assign out_addr  = addr_q;
   assign illegal   = illegal_q;
   assign count     = count_q;

   always_ff @(posedge clk) begin
      if (push_word) begin
         mem[wr_ptr] <= enc_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= 5'd0;
         addr_q    <= BASE_ADDR;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= push && !enc_legal;
         if (push_word) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            addr_q <= addr_q + 32'd4;
         end
         case ({push_word, pop})
            2'b10:   count_q <= count_q + 5'd1;
            2'b01:   count_q <= count_q - 5'd1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef INSTR_ENCODER_ERRCNT_EN
   logic [7:0] err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 8'h00;
      end else if (push && !enc_legal && (err_q != 8'hFF)) begin
         err_q <= err_q + 8'h01;
      end
   end

   assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   localparam logic [31:0] BASE  = 32'hFFFF_FFFC;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  op_idx;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] immediate;
   logic [25:0] address;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [31:0] out_addr;
   logic        illegal;
   logic [4:0]  count;
`ifdef INSTR_ENCODER_ERRCNT_EN
   logic [7:0]  err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_idx(op_idx), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .immediate(immediate), .address(address),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_word(out_word), .out_addr(out_addr),
      .illegal(illegal), .count(count)
`ifdef INSTR_ENCODER_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference encoder (table driven) ----------------
   int sp_idx [29] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16,32,33,34,35,36,44,45,46,49,50,51,52};
   int sp_fn  [29] = '{'h20,'h21,'h22,'h23,'h24,'h25,'h26,'h27,'h2A,'h2B,'h00,'h02,'h03,'h04,'h06,
                      'h07,'h08,'h09,'h11,'h13,'h10,'h12,'h0D,'h0C,'h34,'h18,'h19,'h1A,'h1B};
   int it_idx [19] = '{17,18,19,20,21,22,23,24,25,26,27,28,37,38,39,40,41,42,53};
   int it_op  [19] = '{'h08,'h09,'h0C,'h0D,'h0E,'h23,'h2B,'h04,'h05,'h0A,'h0B,'h0F,
                      'h28,'h29,'h20,'h21,'h24,'h25,'h01};

   function automatic void ref_encode(input int op, input logic [4:0] f_rs, input logic [4:0] f_rt,
                                      input logic [4:0] f_rd, input logic [4:0] f_sh,
                                      input logic [15:0] f_imm, input logic [25:0] f_addr,
                                      output logic [31:0] w, output bit legal);
      logic [31:0] r_s, r_t, r_d, s_h;
      r_s = 32'(f_rs) << 21;
      r_t = 32'(f_rt) << 16;
      r_d = 32'(f_rd) << 11;
      s_h = 32'(f_sh) << 6;
      legal = 1'b1;
      w = 32'h0;
      for (int i = 0; i < 29; i++)
         if (sp_idx[i] == op) begin
            w = r_s | r_t | r_d | s_h | 32'(sp_fn[i]);
            return;
         end
      for (int i = 0; i < 19; i++)
         if (it_idx[i] == op) begin
            w = (32'(it_op[i]) << 26) | r_s | ((op == 53) ? (32'd1 << 16) : r_t) | 32'(f_imm);
            return;
         end
      case (op)
         29: w = (32'd2 << 26) | 32'(f_addr);
         30: w = (32'd3 << 26) | 32'(f_addr);
         31: w = (32'd28 << 26) | r_s | r_t | r_d | 32'd32;
         43: w = 32'h4200_0018;
         47: w = (32'd16 << 26) | r_t | r_d;
         48: w = (32'd16 << 26) | (32'd4 << 21) | r_t | r_d;
         default: legal = 1'b0;
      endcase
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   logic [31:0] m_q[$];
   logic [31:0] m_addr;
   logic        m_ill;
   int          m_err;

   always @(negedge clk) begin
      logic [31:0] w;
      bit          legal;
      bit          push, pop;
      if (!rst) begin
         chk("count", 32'(count), 32'(m_q.size()));
         chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
         chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
         chk("illegal", 32'(illegal), 32'(m_ill));
         chk("out_addr", out_addr, m_addr);
         if (m_q.size() != 0) chk("out_word", out_word, m_q[0]);
`ifdef INSTR_ENCODER_ERRCNT_EN
         chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
      end
      if (rst) begin
         m_q.delete();
         m_addr = BASE;
         m_ill  = 1'b0;
         m_err  = 0;
      end else begin
         push  = in_valid && (m_q.size() < DEPTH);
         pop   = out_ready && (m_q.size() != 0);
         m_ill = 1'b0;
         if (pop) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 32'd4;
         end
         if (push) begin
            ref_encode(int'(op_idx), rs, rt, rd, shamt, immediate, address, w, legal);
            if (legal) m_q.push_back(w);
            else begin
               m_ill = 1'b1;
               if (m_err < 255) m_err++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int op);
      op_idx    = 6'(op);
      rs        = 5'($urandom);
      rt        = 5'($urandom);
      rd        = 5'($urandom);
      shamt     = 5'($urandom);
      immediate = 16'($urandom);
      address   = 26'($urandom);
   endtask

   initial begin
      logic [31:0] w;
      bit          legal;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      set_req(0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // pin the reference model with hand-computed words
      ref_encode(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, w, legal);
      chk("model_add", w, 32'h0022_1820);
      ref_encode(22, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, w, legal);
      chk("model_lw", w, 32'h8FA8_0004);
      ref_encode(29, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000, w, legal);
      chk("model_j", w, 32'h0810_0000);
      ref_encode(53, 5'd2, 5'd7, 5'd9, 5'd3, 16'h0010, 26'h0, w, legal);
      chk("model_bgez", w, 32'h0441_0010);
      ref_encode(47, 5'd31, 5'd5, 5'd12, 5'd0, 16'h0, 26'h0, w, legal);
      chk("model_mfc0", w, 32'h4005_6000);
      ref_encode(60, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, w, legal);
      chk("model_illegal", 32'(legal), 32'd0);

      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_addr", out_addr, BASE);

      // ADD word, latency 1, then address wraps past 2^32
      out_ready = 1'b1;
      set_req(0); rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_word", out_word, 32'h0022_1820);
      chk("add_addr", out_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr", out_addr, 32'h0000_0000);

      // LW then J
      out_ready = 1'b0;
      set_req(22); rs = 5'd29; rt = 5'd8; immediate = 16'h0004;
      in_valid = 1'b1;
      tick();
      set_req(29); address = 26'h010_0000;
      tick();
      in_valid = 1'b0;
      chk("lw_word", out_word, 32'h8FA8_0004);
      chk("lw_addr", out_addr, 32'h0000_0000);
      out_ready = 1'b1;
      tick();
      chk("j_word", out_word, 32'h0810_0000);
      chk("j_addr", out_addr, 32'h0000_0004);
      tick();

      // fill to DEPTH with a fifth request held back, then drain
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (in_ready) set_req(int'($urandom_range(0, 53)));
         tick();
      end
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("drain_count", 32'(count), 32'd0);

      // illegal op_idx
      set_req(60);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ill_pulse", 32'(illegal), 32'd1);
      chk("ill_count", 32'(count), 32'd0);
`ifdef INSTR_ENCODER_ERRCNT_EN
      chk("ill_err_cnt", 32'(err_cnt), 32'd1);
`endif
      tick();
      chk("ill_drop", 32'(illegal), 32'd0);

      // reset with three queued words and a request pending
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_req(int'($urandom_range(0, 53)));
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 32'd3);
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_addr", out_addr, BASE);

      // randomized traffic, all checked by the per-cycle compare
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 299) == 0);
         set_req(($urandom_range(0, 7) == 0) ? int'($urandom_range(54, 63))
                                             : int'($urandom_range(0, 53)));
         tick();
      end
      rst = 1'b0; in_valid = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
